// File: rtl/control_pkg.sv
// Shared encodings for the multicycle controller and the datapath it drives:
// state codes, opcodes, mux/ALU select values and the bundled control word.
package control_pkg;

  typedef enum logic [4:0] {
    ST_RST     = 5'd0,
    ST_FETCH   = 5'd1,
    ST_DECODE  = 5'd2,
    ST_EX_R    = 5'd3,
    ST_EX_I    = 5'd4,
    ST_WB_ALU  = 5'd5,
    ST_MEM_ADR = 5'd6,
    ST_MEM_RD  = 5'd7,
    ST_MEM_WB  = 5'd8,
    ST_MEM_WR  = 5'd9,
    ST_LLI     = 5'd10,
    ST_SLLI    = 5'd11,
    ST_CMP     = 5'd12,
    ST_BR      = 5'd13,
    ST_JMP     = 5'd14,
    ST_OUT     = 5'd15,
    ST_HALT    = 5'd16
  } state_t;

  localparam logic [4:0] OP_ADD  = 5'h00;
  localparam logic [4:0] OP_SUB  = 5'h01;
  localparam logic [4:0] OP_AND  = 5'h02;
  localparam logic [4:0] OP_OR   = 5'h03;
  localparam logic [4:0] OP_ADDI = 5'h04;
  localparam logic [4:0] OP_SUBI = 5'h05;
  localparam logic [4:0] OP_ANDI = 5'h06;
  localparam logic [4:0] OP_ORI  = 5'h07;
  localparam logic [4:0] OP_LW   = 5'h08;
  localparam logic [4:0] OP_SW   = 5'h09;
  localparam logic [4:0] OP_LLI  = 5'h0A;
  localparam logic [4:0] OP_SLLI = 5'h0B;
  localparam logic [4:0] OP_CMP  = 5'h0C;
  localparam logic [4:0] OP_BR   = 5'h0D;
  localparam logic [4:0] OP_JMP  = 5'h0E;
  localparam logic [4:0] OP_OUT  = 5'h0F;
  localparam logic [4:0] OP_HALT = 5'h10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  localparam logic [1:0] IORD_PC     = 2'b00;
  localparam logic [1:0] IORD_ALUOUT = 2'b01;

  localparam logic [1:0] RS_ALUOUT = 2'b00;
  localparam logic [1:0] RS_MDR    = 2'b01;
  localparam logic [1:0] RS_IMM    = 2'b10;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  localparam logic [1:0] SRCA_PC = 2'b00;
  localparam logic [1:0] SRCA_A  = 2'b01;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_TWO   = 2'b01;
  localparam logic [1:0] SRCB_SEXT  = 2'b10;
  localparam logic [1:0] SRCB_SHIFT = 2'b11;

  typedef struct packed {
    logic [1:0] iord;
    logic [1:0] aluop;
    logic [1:0] regsrc;
    logic [1:0] pcsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic       memw;
    logic       regw;
    logic       mdrw;
    logic       srw;
    logic       irw;
    logic       pcw;
    logic       compcodew;
    logic       outputw;
    logic       aluoutw;
    logic       islli;
    logic       isslli;
    logic       isdecode;
    logic       illegal;
    logic       halted;
  } ctrl_t;

endpackage

// File: rtl/control_decode.sv
// Combinational state-to-control decoder; every field not set for a state is 0.
import control_pkg::*;

module control_decode (
  input  state_t     state,
  input  logic [1:0] alu_fn,
  input  logic       cond_true,
  input  logic       bad_op,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      ST_FETCH: begin
        ctrl.iord    = IORD_PC;
        ctrl.irw     = 1'b1;
        ctrl.alusrca = SRCA_PC;
        ctrl.alusrcb = SRCB_TWO;
        ctrl.aluop   = ALU_ADD;
        ctrl.pcsrc   = PCS_ALU;
        ctrl.pcw     = 1'b1;
      end
      ST_DECODE: begin
        ctrl.isdecode = 1'b1;
        ctrl.alusrca  = SRCA_PC;
        ctrl.alusrcb  = SRCB_SHIFT;
        ctrl.aluop    = ALU_ADD;
        ctrl.aluoutw  = 1'b1;
        ctrl.illegal  = bad_op;
      end
      ST_EX_R: begin
        ctrl.alusrca = SRCA_A;
        ctrl.alusrcb = SRCB_B;
        ctrl.aluop   = alu_fn;
        ctrl.aluoutw = 1'b1;
      end
      ST_EX_I: begin
        ctrl.alusrca = SRCA_A;
        ctrl.alusrcb = SRCB_SEXT;
        ctrl.aluop   = alu_fn;
        ctrl.aluoutw = 1'b1;
      end
      ST_WB_ALU: begin
        ctrl.regsrc = RS_ALUOUT;
        ctrl.regw   = 1'b1;
      end
      ST_MEM_ADR: begin
        ctrl.alusrca = SRCA_A;
        ctrl.alusrcb = SRCB_SEXT;
        ctrl.aluop   = ALU_ADD;
        ctrl.aluoutw = 1'b1;
      end
      ST_MEM_RD: begin
        ctrl.iord = IORD_ALUOUT;
        ctrl.mdrw = 1'b1;
      end
      ST_MEM_WB: begin
        ctrl.regsrc = RS_MDR;
        ctrl.regw   = 1'b1;
      end
      ST_MEM_WR: begin
        ctrl.iord = IORD_ALUOUT;
        ctrl.memw = 1'b1;
      end
      ST_LLI: begin
        ctrl.islli  = 1'b1;
        ctrl.regsrc = RS_IMM;
        ctrl.regw   = 1'b1;
      end
      ST_SLLI: begin
        ctrl.isslli = 1'b1;
        ctrl.regsrc = RS_IMM;
        ctrl.regw   = 1'b1;
      end
      ST_CMP: begin
        ctrl.alusrca   = SRCA_A;
        ctrl.alusrcb   = SRCB_B;
        ctrl.aluop     = ALU_SUB;
        ctrl.compcodew = 1'b1;
        ctrl.srw       = 1'b1;
      end
      ST_BR: begin
        ctrl.pcsrc = PCS_ALUOUT;
        ctrl.pcw   = cond_true;
      end
      ST_JMP: begin
        ctrl.pcsrc = PCS_JUMP;
        ctrl.pcw   = 1'b1;
      end
      ST_OUT:  ctrl.outputw = 1'b1;
      ST_HALT: ctrl.halted  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM: sequences fetch/decode/execute/memory/writeback
// and drives every datapath control input; state is also exported on state_dbg.
import control_pkg::*;

module multicycle_control #(
  parameter int OPCODE_W     = 5,
  parameter bit ILLEGAL_TRAP = 1'b0
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                cond_true,
  output logic [1:0]          IorD,
  output logic [1:0]          aluop,
  output logic [1:0]          regsrc,
  output logic [1:0]          pcsrc,
  output logic [1:0]          aluSrcA,
  output logic [1:0]          aluSrcB,
  output logic                memw,
  output logic                regw,
  output logic                mdrw,
  output logic                srw,
  output logic                irw,
  output logic                pcw,
  output logic                compcodew,
  output logic                outputw,
  output logic                aluoutw,
  output logic                isLLI,
  output logic                isSLLI,
  output logic                isDecode,
  output logic                illegal,
  output logic                halted,
  output logic [4:0]          state_dbg
);

  state_t     state, state_nxt;
  logic [1:0] alu_fn;
  logic       bad_op;
  ctrl_t      ctrl;

  assign bad_op = opcode > OPCODE_W'(OP_HALT);

  // alu_fn holds the ALU function captured in DECODE, so the execute states
  // do not depend on opcode staying stable after decode.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state  <= ST_RST;
      alu_fn <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_DECODE) alu_fn <= opcode[1:0];
    end
  end

  always_comb begin
    state_nxt = ST_FETCH;
    case (state)
      ST_RST:   state_nxt = ST_FETCH;
      ST_FETCH: state_nxt = ST_DECODE;
      ST_DECODE: begin
        if (opcode <= OPCODE_W'(OP_OR))                                   state_nxt = ST_EX_R;
        else if (opcode <= OPCODE_W'(OP_ORI))                             state_nxt = ST_EX_I;
        else if (opcode == OPCODE_W'(OP_LW) || opcode == OPCODE_W'(OP_SW)) state_nxt = ST_MEM_ADR;
        else if (opcode == OPCODE_W'(OP_LLI))                             state_nxt = ST_LLI;
        else if (opcode == OPCODE_W'(OP_SLLI))                            state_nxt = ST_SLLI;
        else if (opcode == OPCODE_W'(OP_CMP))                             state_nxt = ST_CMP;
        else if (opcode == OPCODE_W'(OP_BR))                              state_nxt = ST_BR;
        else if (opcode == OPCODE_W'(OP_JMP))                             state_nxt = ST_JMP;
        else if (opcode == OPCODE_W'(OP_OUT))                             state_nxt = ST_OUT;
        else if (opcode == OPCODE_W'(OP_HALT))                            state_nxt = ST_HALT;
        else                                      state_nxt = ILLEGAL_TRAP ? ST_HALT : ST_FETCH;
      end
      ST_EX_R, ST_EX_I: state_nxt = ST_WB_ALU;
      ST_MEM_ADR: state_nxt = (opcode == OPCODE_W'(OP_LW)) ? ST_MEM_RD : ST_MEM_WR;
      ST_MEM_RD:  state_nxt = ST_MEM_WB;
      ST_HALT:    state_nxt = ST_HALT;
      // every other state finishes its instruction; unknown codes recover here too
      default:    state_nxt = ST_FETCH;
    endcase
  end

  control_decode u_decode (
    .state     (state),
    .alu_fn    (alu_fn),
    .cond_true (cond_true),
    .bad_op    (bad_op),
    .ctrl      (ctrl)
  );

  assign IorD      = ctrl.iord;
  assign aluop     = ctrl.aluop;
  assign regsrc    = ctrl.regsrc;
  assign pcsrc     = ctrl.pcsrc;
  assign aluSrcA   = ctrl.alusrca;
  assign aluSrcB   = ctrl.alusrcb;
  assign memw      = ctrl.memw;
  assign regw      = ctrl.regw;
  assign mdrw      = ctrl.mdrw;
  assign srw       = ctrl.srw;
  assign irw       = ctrl.irw;
  assign pcw       = ctrl.pcw;
  assign compcodew = ctrl.compcodew;
  assign outputw   = ctrl.outputw;
  assign aluoutw   = ctrl.aluoutw;
  assign isLLI     = ctrl.islli;
  assign isSLLI    = ctrl.isslli;
  assign isDecode  = ctrl.isdecode;
  assign illegal   = ctrl.illegal;
  assign halted    = ctrl.halted;
  assign state_dbg = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-cycle expected control words from a
// reference table, with a second instance built with the illegal-opcode trap.
module tb_multicycle_control;

  localparam int B_RST = 0, B_FETCH = 1, B_DECODE = 2, B_EXR = 3, B_EXI = 4,
                 B_WBALU = 5, B_MADR = 6, B_MRD = 7, B_MWB = 8, B_MWR = 9,
                 B_LLI = 10, B_SLLI = 11, B_CMP = 12, B_BR = 13, B_JMP = 14,
                 B_OUT = 15, B_HALT = 16;

  logic       CLK = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] opcode = '0;
  logic       cond_true = 1'b0;

  logic [1:0] IorD, aluop, regsrc, pcsrc, aluSrcA, aluSrcB;
  logic memw, regw, mdrw, srw, irw, pcw, compcodew, outputw, aluoutw;
  logic isLLI, isSLLI, isDecode, illegal, halted;
  logic [4:0] state_dbg;

  logic [1:0] t_IorD, t_aluop, t_regsrc, t_pcsrc, t_aluSrcA, t_aluSrcB;
  logic t_memw, t_regw, t_mdrw, t_srw, t_irw, t_pcw, t_compcodew, t_outputw, t_aluoutw;
  logic t_isLLI, t_isSLLI, t_isDecode, t_illegal, t_halted;
  logic [4:0] t_state_dbg;

  logic [25:0] obs, t_obs;
  logic [25:0] exp_q[$];
  int n_checks = 0;
  int n_pass = 0;

  // clock / reset
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  multicycle_control #(.OPCODE_W(5), .ILLEGAL_TRAP(1'b0)) dut (
    .CLK(CLK), .reset(reset), .opcode(opcode), .cond_true(cond_true),
    .IorD(IorD), .aluop(aluop), .regsrc(regsrc), .pcsrc(pcsrc),
    .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .memw(memw), .regw(regw),
    .mdrw(mdrw), .srw(srw), .irw(irw), .pcw(pcw), .compcodew(compcodew),
    .outputw(outputw), .aluoutw(aluoutw), .isLLI(isLLI), .isSLLI(isSLLI),
    .isDecode(isDecode), .illegal(illegal), .halted(halted), .state_dbg(state_dbg)
  );

  multicycle_control #(.OPCODE_W(5), .ILLEGAL_TRAP(1'b1)) dut_trap (
    .CLK(CLK), .reset(reset), .opcode(opcode), .cond_true(cond_true),
    .IorD(t_IorD), .aluop(t_aluop), .regsrc(t_regsrc), .pcsrc(t_pcsrc),
    .aluSrcA(t_aluSrcA), .aluSrcB(t_aluSrcB), .memw(t_memw), .regw(t_regw),
    .mdrw(t_mdrw), .srw(t_srw), .irw(t_irw), .pcw(t_pcw), .compcodew(t_compcodew),
    .outputw(t_outputw), .aluoutw(t_aluoutw), .isLLI(t_isLLI), .isSLLI(t_isSLLI),
    .isDecode(t_isDecode), .illegal(t_illegal), .halted(t_halted), .state_dbg(t_state_dbg)
  );

  assign obs = {IorD, aluop, regsrc, pcsrc, aluSrcA, aluSrcB, memw, regw, mdrw, srw,
                irw, pcw, compcodew, outputw, aluoutw, isLLI, isSLLI, isDecode,
                illegal, halted};
  assign t_obs = {t_IorD, t_aluop, t_regsrc, t_pcsrc, t_aluSrcA, t_aluSrcB, t_memw,
                  t_regw, t_mdrw, t_srw, t_irw, t_pcw, t_compcodew, t_outputw,
                  t_aluoutw, t_isLLI, t_isSLLI, t_isDecode, t_illegal, t_halted};

  // reference control word per state, taken from the state/output table
  function automatic logic [25:0] exp_vec(input int s, input logic [1:0] fn,
                                          input logic ct, input logic ill);
    logic [1:0] iord, aop, rsrc, psrc, sa, sb;
    logic mw, rw, dw, sw, iw, pw, cw, ow, aw, lli, slli, dec, il, hl;
    {iord, aop, rsrc, psrc, sa, sb} = '0;
    {mw, rw, dw, sw, iw, pw, cw, ow, aw, lli, slli, dec, il, hl} = '0;
    case (s)
      B_FETCH:  begin iw = 1'b1; sb = 2'b01; pw = 1'b1; end
      B_DECODE: begin dec = 1'b1; sb = 2'b11; aw = 1'b1; il = ill; end
      B_EXR:    begin sa = 2'b01; aop = fn; aw = 1'b1; end
      B_EXI:    begin sa = 2'b01; sb = 2'b10; aop = fn; aw = 1'b1; end
      B_WBALU:  rw = 1'b1;
      B_MADR:   begin sa = 2'b01; sb = 2'b10; aw = 1'b1; end
      B_MRD:    begin iord = 2'b01; dw = 1'b1; end
      B_MWB:    begin rsrc = 2'b01; rw = 1'b1; end
      B_MWR:    begin iord = 2'b01; mw = 1'b1; end
      B_LLI:    begin lli = 1'b1; rsrc = 2'b10; rw = 1'b1; end
      B_SLLI:   begin slli = 1'b1; rsrc = 2'b10; rw = 1'b1; end
      B_CMP:    begin sa = 2'b01; aop = 2'b01; cw = 1'b1; sw = 1'b1; end
      B_BR:     begin psrc = 2'b01; pw = ct; end
      B_JMP:    begin psrc = 2'b10; pw = 1'b1; end
      B_OUT:    ow = 1'b1;
      B_HALT:   hl = 1'b1;
      default:  ;
    endcase
    return {iord, aop, rsrc, psrc, sa, sb, mw, rw, dw, sw, iw, pw, cw, ow, aw,
            lli, slli, dec, il, hl};
  endfunction

  // driver: one clock; inputs change just after the edge, outputs checked 1ns later
  task automatic do_cycle(input int s, input logic [1:0] fn, input logic ill,
                          input logic [4:0] op, input logic ct, input string tag);
    logic [25:0] e;
    exp_q.push_back(exp_vec(s, fn, ct, ill));
    @(posedge CLK);
    #1;
    opcode = op;
    cond_true = ct;
    #1;
    e = exp_q.pop_front();
    n_checks++;
    if (obs !== e) $display("FAIL %s state %0d: got %h expected %h", tag, s, obs, e);
    else n_pass++;
  endtask

  task automatic run_op(input logic [4:0] op, input logic ct, input string tag);
    int post[$];
    logic ill;
    ill = (op > 5'h10);
    if (op <= 5'h03)      post = '{B_EXR, B_WBALU};
    else if (op <= 5'h07) post = '{B_EXI, B_WBALU};
    else if (op == 5'h08) post = '{B_MADR, B_MRD, B_MWB};
    else if (op == 5'h09) post = '{B_MADR, B_MWR};
    else if (op == 5'h0A) post = '{B_LLI};
    else if (op == 5'h0B) post = '{B_SLLI};
    else if (op == 5'h0C) post = '{B_CMP};
    else if (op == 5'h0D) post = '{B_BR};
    else if (op == 5'h0E) post = '{B_JMP};
    else if (op == 5'h0F) post = '{B_OUT};
    else if (op == 5'h10) post = '{B_HALT};
    do_cycle(B_FETCH, op[1:0], 1'b0, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), tag);
    do_cycle(B_DECODE, op[1:0], ill, op, 1'($urandom_range(0, 1)), tag);
    foreach (post[i]) begin
      // opcode is garbage outside MEM_ADR to show it is ignored there
      do_cycle(post[i], op[1:0], 1'b0,
               (post[i] == B_MADR) ? op : 5'($urandom_range(0, 31)),
               (post[i] == B_BR) ? ct : 1'($urandom_range(0, 1)), tag);
    end
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    #1;
    n_checks++;
    if (obs !== '0) $display("FAIL %s reset_assert: got %h expected 0", tag, obs);
    else n_pass++;
    @(posedge CLK);
    #1;
    n_checks++;
    if (obs !== '0) $display("FAIL %s reset_hold: got %h expected 0", tag, obs);
    else n_pass++;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if (obs !== '0 || t_obs !== '0) $display("FAIL reset_init: got %h/%h expected 0", obs, t_obs);
    else n_pass++;
    @(posedge CLK);
    #1;
    reset = 1'b1;
    run_op(5'h0E, 1'b0, "jmp_after_reset");
    // mid-instruction reset during LW, landing between clock edges
    do_cycle(B_FETCH, 2'b00, 1'b0, 5'h08, 1'b0, "lw_abort");
    do_cycle(B_DECODE, 2'b00, 1'b0, 5'h08, 1'b0, "lw_abort");
    do_cycle(B_MADR, 2'b00, 1'b0, 5'h08, 1'b0, "lw_abort");
    #3;
    do_reset("lw_abort");
  endtask

  task automatic test_rtype();
    run_op(5'h01, 1'b0, "r_sub");
    run_op(5'h02, 1'b0, "r_and");
    run_op(5'h07, 1'b0, "i_or");
  endtask

  task automatic test_lw_sw();
    run_op(5'h08, 1'b0, "lw");
    run_op(5'h09, 1'b0, "sw");
  endtask

  task automatic test_br();
    run_op(5'h0D, 1'b0, "br_not_taken");
    run_op(5'h0D, 1'b1, "br_taken");
  endtask

  task automatic test_misc();
    run_op(5'h0A, 1'b0, "lli");
    run_op(5'h0B, 1'b0, "slli");
    run_op(5'h0F, 1'b0, "out");
    run_op(5'h0C, 1'b0, "cmp");
  endtask

  task automatic test_halt();
    run_op(5'h10, 1'b0, "halt");
    for (int i = 0; i < 19; i++)
      do_cycle(B_HALT, 2'b00, 1'b0, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), "halt_hold");
    do_reset("halt_clear");
    run_op(5'h00, 1'b0, "add_after_halt");
  endtask

  task automatic test_illegal();
    logic [25:0] e;
    run_op(5'h15, 1'b0, "illegal");
    e = exp_vec(B_DECODE, 2'b00, 1'b0, 1'b1);
    n_checks++;
    if (t_obs !== e) $display("FAIL trap_decode: got %h expected %h", t_obs, e);
    else n_pass++;
    do_cycle(B_FETCH, 2'b00, 1'b0, 5'h00, 1'b0, "illegal_to_fetch");
    e = exp_vec(B_HALT, 2'b00, 1'b0, 1'b0);
    n_checks++;
    if (t_obs !== e) $display("FAIL trap_halt: got %h expected %h", t_obs, e);
    else n_pass++;
    do_reset("trap_clear");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++)
      run_op(5'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), "b2b");
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_sw();
    test_br();
    test_misc();
    test_halt();
    test_illegal();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
